// File: rtl/muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Contents: op encodings, FSM state type, latency constants, divide-by-zero LO default,
// and a conditional two's-complement negate helper.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path; changes MUL_LAT).
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {StIdle, StIter, StFix, StDone} state_e;

    localparam int unsigned ITER_N_DEF = 32;

    // Cycles from the accepting cycle to the write pulse.
    localparam int unsigned DIV_LAT = ITER_N_DEF + 2;
`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MUL_LAT = 3;
`else
    localparam int unsigned MUL_LAT = DIV_LAT;
`endif

    localparam logic [31:0] DIV_ZERO_LO_DEF = 32'hFFFF_FFFF;

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_hilo_ctrl_if.sv
// Issue/result bundle between the EX stage and the multiply/divide sequencer.
// master: issuing pipeline (drives start/op/src_a/src_b/flush, sees stall/busy/result).
// slave : the sequencer.
interface muldiv_hilo_ctrl_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        busy;
    logic        hl_write_enable;
    logic [63:0] hl_data;

    modport master (
        output start, op, src_a, src_b, flush,
        input  stall, busy, hl_write_enable, hl_data
    );

    modport slave (
        input  start, op, src_a, src_b, flush,
        output stall, busy, hl_write_enable, hl_data
    );
endinterface

// File: rtl/muldiv_iter_step.sv
// One iteration of the multi-cycle datapath, purely combinational.
// Ports:
//   i_is_div      : 1 = restoring divide step, 0 = shift-add multiply step
//   i_hi, i_lo    : current accumulator {hi, lo}
//   i_opnd        : multiplicand magnitude (mul) or divisor magnitude (div)
//   o_hi, o_lo    : accumulator after the step
// Mul: lo holds the multiplier, consumed LSB-first; product builds from the top.
// Div: hi holds the partial remainder, lo shifts the dividend out and the quotient in.
module muldiv_iter_step (
    input  logic        i_is_div,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_opnd,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [32:0] w_sum;
    logic [32:0] w_rem_sh;
    logic        w_ge;
    logic [31:0] w_diff;

    always_comb begin
        w_sum    = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : 33'd0);
        w_rem_sh = {i_hi, i_lo[31]};
        w_ge     = (w_rem_sh >= {1'b0, i_opnd});
        // When w_ge holds the true difference is below 2^32, so 32 bits suffice.
        w_diff   = w_rem_sh[31:0] - i_opnd;
        if (i_is_div) begin
            o_hi = w_ge ? w_diff : w_rem_sh[31:0];
            o_lo = {i_lo[30:0], w_ge};
        end else begin
            o_hi = w_sum[32:1];
            o_lo = {w_sum[0], i_lo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_hilo_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer producing the {HI,LO} write for WB.
// Ports:
//   clk, rst : core clock, synchronous active-high reset
//   bus      : slave side of muldiv_hilo_ctrl_if (start/op/src_a/src_b/flush in,
//              stall/busy/hl_write_enable/hl_data out)
// Flow: IDLE -> ITER (ITER_N steps on magnitudes) -> FIX (signs, div-by-zero) -> DONE (pulse).
// Optional macro MULDIV_FAST_MUL_EN: multiplies use one registered `*` stage instead of ITER.
module muldiv_hilo_ctrl
    import muldiv_pkg::*;
#(
    parameter logic [31:0] DIV_ZERO_LO = DIV_ZERO_LO_DEF,
    parameter int unsigned ITER_N      = ITER_N_DEF
) (
    input logic               clk,
    input logic               rst,
    muldiv_hilo_ctrl_if.slave bus
);

    localparam logic [4:0] CNT_LAST = 5'(ITER_N - 1);

    state_e      r_state, w_state_nxt;
    logic [4:0]  r_cnt;
    logic        r_is_div, r_neg_res, r_neg_rem, r_div_zero;
    logic [31:0] r_src_a, r_opnd, r_acc_hi, r_acc_lo;
    logic [63:0] r_hl_data;

    logic        w_accept, w_signed, w_is_div, w_neg_a, w_neg_b, w_fast_iter, w_iter_last;
    logic [31:0] w_step_hi, w_step_lo;
    logic [63:0] w_fix_res;

    assign w_accept = (r_state == StIdle) & bus.start & ~bus.flush;
    assign w_is_div = (bus.op == OP_DIV) | (bus.op == OP_DIVU);
    assign w_signed = (bus.op == OP_MULT) | (bus.op == OP_DIV);
    assign w_neg_a  = w_signed & bus.src_a[31];
    assign w_neg_b  = w_signed & bus.src_b[31];

`ifdef MULDIV_FAST_MUL_EN
    logic        r_fast, r_signed;
    logic [31:0] r_src_b;
    logic [63:0] w_fa, w_fb, w_fast_prod;
    // Low 64 bits of the extended operands' product equal the 33x33 signed/unsigned result.
    assign w_fa        = r_signed ? {{32{r_src_a[31]}}, r_src_a} : {32'd0, r_src_a};
    assign w_fb        = r_signed ? {{32{r_src_b[31]}}, r_src_b} : {32'd0, r_src_b};
    assign w_fast_prod = w_fa * w_fb;
    assign w_fast_iter = r_fast;
`else
    assign w_fast_iter = 1'b0;
`endif

    assign w_iter_last = (r_cnt == CNT_LAST) | w_fast_iter;

    muldiv_iter_step u_step (
        .i_is_div (r_is_div),
        .i_hi     (r_acc_hi),
        .i_lo     (r_acc_lo),
        .i_opnd   (r_opnd),
        .o_hi     (w_step_hi),
        .o_lo     (w_step_lo)
    );

    always_comb begin
        if (!r_is_div) begin
            w_fix_res = r_neg_res ? (~{r_acc_hi, r_acc_lo} + 64'd1) : {r_acc_hi, r_acc_lo};
        end else if (r_div_zero) begin
            w_fix_res = {r_src_a, DIV_ZERO_LO};
        end else begin
            w_fix_res = {neg_if(r_acc_hi, r_neg_rem), neg_if(r_acc_lo, r_neg_res)};
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle:  if (w_accept) w_state_nxt = StIter;
            StIter:  if (w_iter_last) w_state_nxt = StFix;
            StFix:   w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
        if (bus.flush) w_state_nxt = StIdle;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_div_zero <= 1'b0;
            r_src_a    <= '0;
            r_opnd     <= '0;
            r_acc_hi   <= '0;
            r_acc_lo   <= '0;
            r_hl_data  <= '0;
`ifdef MULDIV_FAST_MUL_EN
            r_fast     <= 1'b0;
            r_signed   <= 1'b0;
            r_src_b    <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_is_div   <= w_is_div;
                        r_neg_res  <= w_neg_a ^ w_neg_b;
                        r_neg_rem  <= w_neg_a;
                        r_div_zero <= w_is_div & (bus.src_b == 32'd0);
                        r_src_a    <= bus.src_a;
                        r_acc_hi   <= '0;
                        // Mul: mcand in r_opnd, multiplier in lo. Div: divisor in r_opnd,
                        // dividend in lo.
                        r_opnd     <= w_is_div ? neg_if(bus.src_b, w_neg_b)
                                               : neg_if(bus.src_a, w_neg_a);
                        r_acc_lo   <= w_is_div ? neg_if(bus.src_a, w_neg_a)
                                               : neg_if(bus.src_b, w_neg_b);
`ifdef MULDIV_FAST_MUL_EN
                        r_fast     <= ~w_is_div;
                        r_signed   <= w_signed;
                        r_src_b    <= bus.src_b;
                        // The fast product is already signed; no fixup negate.
                        if (!w_is_div) r_neg_res <= 1'b0;
`endif
                    end
                end
                StIter: begin
                    r_acc_hi <= w_step_hi;
                    r_acc_lo <= w_step_lo;
                    r_cnt    <= r_cnt + 5'd1;
`ifdef MULDIV_FAST_MUL_EN
                    if (r_fast) {r_acc_hi, r_acc_lo} <= w_fast_prod;
`endif
                end
                StFix: begin
                    if (!bus.flush) r_hl_data <= w_fix_res;
                end
                StDone: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.stall           = w_accept | (r_state == StIter) | (r_state == StFix);
    assign bus.busy            = (r_state != StIdle);
    assign bus.hl_write_enable = (r_state == StDone) & ~bus.flush;
    assign bus.hl_data         = r_hl_data;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Self-checking bench for muldiv_hilo_ctrl: expected {HI,LO} and pulse cycle are queued
// at issue and compared when hl_write_enable fires.
module tb_muldiv_hilo_ctrl;

`ifdef MULDIV_FAST_MUL_EN
    localparam int unsigned MUL_LAT_EXP = 3;
`else
    localparam int unsigned MUL_LAT_EXP = 34;
`endif
    localparam int unsigned DIV_LAT_EXP = 34;

    typedef struct {
        logic [63:0] data;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cyc;
    int unsigned n_checks;
    int unsigned n_fail;
    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [63:0] last_exp;

    muldiv_hilo_ctrl_if u_if ();

    muldiv_hilo_ctrl u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] pa, pb;
        int sa, sb;
        case (o)
            2'b00: begin
                pa = {{32{a[31]}}, a};
                pb = {{32{b[31]}}, b};
                return pa * pb;
            end
            2'b01: return {32'd0, a} * {32'd0, b};
            2'b10: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a;
                sb = b;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int unsigned lat_of(input logic [1:0] o);
        return o[1] ? DIV_LAT_EXP : MUL_LAT_EXP;
    endfunction

    // Call at posedge+#1 with the DUT idle; returns at posedge+#1 of the next cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push);
        u_if.start = 1'b1;
        u_if.op    = o;
        u_if.src_a = a;
        u_if.src_b = b;
        if (push) sb_q.push_back('{data: model(o, a, b), due: cyc + lat_of(o)});
        @(negedge clk);
        check_eq("issue_stall", 64'(u_if.stall), 64'd1);
        check_eq("issue_busy", 64'(u_if.busy), 64'd0);
        @(posedge clk);
        #1;
        u_if.start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u_if.busy && n < 200);
        check_eq("idle_timeout", 64'(u_if.busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        issue(o, a, b, 1'b1);
        wait_idle();
    endtask

    always @(negedge clk) begin
        if (u_if.hl_write_enable) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_pulse", 64'(u_if.hl_write_enable), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("hl_data", u_if.hl_data, mon_e.data);
                check_eq("pulse_cycle", 64'(cyc), 64'(mon_e.due));
                last_exp = mon_e.data;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        last_exp = 64'd0;
        rst = 1'b1;
        u_if.start = 1'b0;
        u_if.op    = 2'b00;
        u_if.src_a = 32'd0;
        u_if.src_b = 32'd0;
        u_if.flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", 64'(u_if.busy), 64'd0);
        check_eq("rst_stall", 64'(u_if.stall), 64'd0);
        check_eq("rst_we", 64'(u_if.hl_write_enable), 64'd0);
        check_eq("rst_data", u_if.hl_data, 64'd0);
        @(posedge clk);
        #1;

        // MULT -1 * 2 with a cycle-by-cycle stall/busy profile.
        issue(2'b00, 32'hFFFF_FFFF, 32'd2, 1'b1);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (MUL_LAT_EXP == 34) begin
                check_eq("mult_stall", 64'(u_if.stall), (k <= 33) ? 64'd1 : 64'd0);
                check_eq("mult_busy", 64'(u_if.busy), 64'd1);
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_eq("mult_busy_after", 64'(u_if.busy), 64'd0);
        check_eq("mult_data", u_if.hl_data, 64'hFFFF_FFFF_FFFF_FFFE);
        @(posedge clk);
        #1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'd2);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(2'b11, 32'd100, 32'd0);
        run_op(2'b10, 32'hFFFF_FF9C, 32'd0);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 8; i++) begin
            logic [1:0]  ro;
            logic [31:0] ra, rb;
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = (i % 3 == 0) ? $urandom_range(0, 5) : $urandom;
            run_op(ro, ra, rb);
        end

        // Flush at T+10: no pulse, hl_data held, new start at T+11 accepted.
        issue(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        u_if.flush = 1'b1;
        @(posedge clk);
        #1;
        u_if.flush = 1'b0;
        issue(2'b11, 32'd1000, 32'd7, 1'b1);
        @(negedge clk);
        check_eq("flush_hold", u_if.hl_data, last_exp);
        wait_idle();

        // Reset at T+10: outputs back to reset values.
        issue(2'b11, 32'd1000, 32'd3, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_exp = 64'd0;
        @(negedge clk);
        check_eq("midrst_busy", 64'(u_if.busy), 64'd0);
        check_eq("midrst_stall", 64'(u_if.stall), 64'd0);
        check_eq("midrst_data", u_if.hl_data, 64'd0);
        repeat (40) begin
            @(negedge clk);
            check_eq("midrst_no_pulse", 64'(u_if.hl_write_enable), 64'd0);
        end
        @(posedge clk);
        #1;

        // Stray start during ITER ignored; back-to-back start right after DONE.
        if (MUL_LAT_EXP == 34) begin
            issue(2'b01, 32'h1234_5678, 32'h0000_9ABC, 1'b1);
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            u_if.start = 1'b1;
            u_if.op    = 2'b10;
            u_if.src_a = 32'hDEAD_BEEF;
            u_if.src_b = 32'd5;
            @(posedge clk);
            #1;
            u_if.start = 1'b0;
            repeat (29) begin
                @(posedge clk);
                #1;
            end
            issue(2'b11, 32'd1000, 32'd7, 1'b1);
            wait_idle();
        end else begin
            issue(2'b10, 32'd77, 32'd5, 1'b1);
            repeat (4) begin
                @(posedge clk);
                #1;
            end
            u_if.start = 1'b1;
            u_if.op    = 2'b01;
            u_if.src_a = 32'hDEAD_BEEF;
            u_if.src_b = 32'd5;
            @(posedge clk);
            #1;
            u_if.start = 1'b0;
            wait_idle();
        end

        repeat (5) @(posedge clk);
        check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
